// File: rtl/kbd_pkg.sv
// Shared scan-code constants, held-key bit indices and receiver state encoding
// for the PS/2 keyboard front end and its consumers.
package kbd_pkg;

    localparam logic [7:0] SC_W   = 8'h1D;
    localparam logic [7:0] SC_A   = 8'h1C;
    localparam logic [7:0] SC_S   = 8'h1B;
    localparam logic [7:0] SC_D   = 8'h23;
    localparam logic [7:0] SC_L   = 8'h4B;
    localparam logic [7:0] SC_F1  = 8'h05;
    localparam logic [7:0] SC_F2  = 8'h06;
    localparam logic [7:0] SC_F3  = 8'h04;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_EXT = 8'hE0;

    localparam logic [2:0] KEY_W  = 3'd0;
    localparam logic [2:0] KEY_A  = 3'd1;
    localparam logic [2:0] KEY_S  = 3'd2;
    localparam logic [2:0] KEY_D  = 3'd3;
    localparam logic [2:0] KEY_L  = 3'd4;
    localparam logic [2:0] KEY_F1 = 3'd5;
    localparam logic [2:0] KEY_F2 = 3'd6;
    localparam logic [2:0] KEY_F3 = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // Maps a non-prefix set-2 code onto its bit in the held-key bitmap.
    function automatic key_hit_t key_lookup(input logic [7:0] sc);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = KEY_W;
        case (sc)
            SC_W:    r.idx = KEY_W;
            SC_A:    r.idx = KEY_A;
            SC_S:    r.idx = KEY_S;
            SC_D:    r.idx = KEY_D;
            SC_L:    r.idx = KEY_L;
            SC_F1:   r.idx = KEY_F1;
            SC_F2:   r.idx = KEY_F2;
            SC_F3:   r.idx = KEY_F3;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the PS/2 line inputs and the decoded keyboard outputs.
// code_valid / frame_err are single-cycle strobes with no ready: the consumer must
// take scan_code on the cycle code_valid is high, there is no back-pressure.
interface ps2_key_decoder_if;
    import kbd_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keyboard_data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;
    rx_state_e  rx_state;

    modport slave (
        input  ps2_clk, ps2_data,
        output keyboard_data, scan_code, code_valid, frame_err, rx_state
    );

    modport master (
        output ps2_clk, ps2_data,
        input  keyboard_data, scan_code, code_valid, frame_err, rx_state
    );

endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 device-to-host byte receiver: line synchronisers, ps2_clk glitch filter,
// 11-bit frame FSM with odd-parity/stop checking and a mid-frame timeout.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output rx_state_e  rx_state
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_filt, clk_filt_q;
    logic [FW-1:0] flt_cnt;
    logic          fall, data_bit, timed_out;

    rx_state_e     state, state_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shift, shift_d;
    logic          par, par_d;
    logic          valid_d, err_d;
    logic [TW-1:0] to_cnt;

    // Lines idle high, so the synchronisers and filter come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            clk_filt_q <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall      = clk_filt_q & ~clk_filt;
    assign data_bit  = dat_sync[1];
    assign timed_out = (state != RX_IDLE) && (to_cnt == TO_LAST) && !fall;

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        par_d     = par;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (timed_out) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE: begin
                    if (!data_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {data_bit, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = data_bit;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (data_bit && (^{shift, par})) valid_d = 1'b1;
                    else                             err_d   = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            to_cnt   <= '0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            par      <= par_d;
            rx_valid <= valid_d;
            rx_err   <= err_d;
            if (valid_d) rx_byte <= shift;
            if (fall || state == RX_IDLE) to_cnt <= '0;
            else                          to_cnt <= to_cnt + 1'b1;
        end
    end

    assign rx_state = state;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: receives set-2 bytes and keeps the held-key bitmap
// for the mapped game keys, tracking the break (F0) and extended (E0) prefixes.
module ps2_key_decoder
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               clk,
    input  logic               reset,
    ps2_key_decoder_if.slave   bus
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    rx_state_e  rx_state;
    logic [7:0] keys;
    logic       brk, ext;
    key_hit_t   hit;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_state (rx_state)
    );

    assign hit = key_lookup(rx_byte);

    // Prefixes accumulate until a non-prefix byte consumes them; errored frames never reach here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys <= '0;
            brk  <= 1'b0;
            ext  <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_BRK) begin
                brk <= 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else begin
                if (!ext && hit.hit) keys[hit.idx] <= !brk;
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    assign bus.keyboard_data = keys;
    assign bus.scan_code     = rx_byte;
    assign bus.code_valid    = rx_valid;
    assign bus.frame_err     = rx_err;
    assign bus.rx_state      = rx_state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames, scoreboards received bytes and
// tracks the held-key bitmap with an independent model.
module tb_ps2_key_decoder;
    import kbd_pkg::*;

    // PS/2 timing is scaled down so the whole run stays short.
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HALF        = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_keys = '0;
    logic m_brk = 1'b0, m_ext = 1'b0, kbd_pend = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tb_key_idx(input logic [7:0] b);
        case (b)
            8'h1D: return 0;
            8'h1C: return 1;
            8'h1B: return 2;
            8'h23: return 3;
            8'h4B: return 4;
            8'h05: return 5;
            8'h06: return 6;
            8'h04: return 7;
            default: return -1;
        endcase
    endfunction

    // Scoreboard and bitmap model, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            m_keys = '0; m_brk = 1'b0; m_ext = 1'b0; kbd_pend = 1'b0;
        end else begin
            if (kbd_pend) begin
                check_eq("kbd_after_valid", 32'(bus.keyboard_data), 32'(m_keys));
                kbd_pend = 1'b0;
            end
            if (bus.frame_err) err_cnt++;
            if (bus.code_valid) begin
                logic [7:0] e;
                int idx;
                valid_cnt++;
                check_eq("sb_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("scan_code", 32'(bus.scan_code), 32'(e));
                    if (e == 8'hF0) m_brk = 1'b1;
                    else if (e == 8'hE0) m_ext = 1'b1;
                    else begin
                        idx = tb_key_idx(e);
                        if (!m_ext && idx >= 0) m_keys[idx] = !m_brk;
                        m_brk = 1'b0; m_ext = 1'b0;
                    end
                    kbd_pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of an 11-bit frame; data changes mid-high.
    task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (nbits == 11 && !bad_par) exp_q.push_back(b);
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(HALF / 2);
            bus.ps2_data = f[i];
            wait_cyc(HALF / 2);
            bus.ps2_clk = 1'b0;
            wait_cyc(HALF);
            bus.ps2_clk = 1'b1;
        end
        wait_cyc(HALF / 2);
        bus.ps2_data = 1'b1;
        wait_cyc(2 * HALF);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        ps2_frame(b, 1'b0, 11);
    endtask

    task automatic do_reset();
        wait_cyc(1);
        reset = 1'b1;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        exp_q.delete();
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(3);
    endtask

    task automatic check_kbd(input string tag, input logic [7:0] exp);
        check_eq(tag, 32'(bus.keyboard_data), 32'(exp));
    endtask

    initial begin
        int v0, e0;
        logic [7:0] rnd_tbl [8];
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cyc(5);
        @(negedge clk);
        check_kbd("reset_kbd", 8'h00);
        check_eq("reset_scan", 32'(bus.scan_code), 32'h0);
        check_eq("reset_valid", 32'(bus.code_valid), 32'h0);
        check_eq("reset_err", 32'(bus.frame_err), 32'h0);
        check_eq("reset_state", 32'(bus.rx_state), 32'(RX_IDLE));
        reset = 1'b0;
        wait_cyc(3);

        // 1: single make
        v0 = valid_cnt;
        send(8'h1D);
        check_eq("t1_valid_once", 32'(valid_cnt - v0), 32'd1);
        check_eq("t1_scan", 32'(bus.scan_code), 32'h1D);
        check_kbd("t1_kbd", 8'h01);

        // 2: two makes, then break of W
        send(8'h1C); check_kbd("t2_make_a", 8'h03);
        send(8'hF0); check_kbd("t2_f0_alone", 8'h03);
        send(8'h1D); check_kbd("t2_break_w", 8'h02);

        // 3: parity errors leave bitmap and prefixes alone
        do_reset();
        send(8'h1C); check_kbd("t3_pre", 8'h02);
        v0 = valid_cnt; e0 = err_cnt;
        ps2_frame(8'h4B, 1'b1, 11);
        check_eq("t3_err", 32'(err_cnt - e0), 32'd1);
        check_eq("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check_kbd("t3_kbd", 8'h02);
        send(8'hF0);
        ps2_frame(8'h1C, 1'b1, 11);
        send(8'h1C);
        check_kbd("t3_brk_kept", 8'h00);

        // 4: truncated frame times out
        do_reset();
        e0 = err_cnt;
        ps2_frame(8'h23, 1'b0, 5);
        check_eq("t4_no_early_err", 32'(err_cnt - e0), 32'd0);
        wait_cyc(TIMEOUT_CYC);
        @(negedge clk);
        check_eq("t4_timeout_err", 32'(err_cnt - e0), 32'd1);
        check_eq("t4_idle", 32'(bus.rx_state), 32'(RX_IDLE));
        send(8'h23); check_kbd("t4_kbd", 8'h08);

        // 5: extended codes are ignored
        do_reset();
        v0 = valid_cnt;
        send(8'hE0); send(8'h1D); check_kbd("t5_ext_make", 8'h00);
        send(8'hE0); send(8'hF0); send(8'h1D); check_kbd("t5_ext_brk", 8'h00);
        check_eq("t5_valid_cnt", 32'(valid_cnt - v0), 32'd5);

        // 6: reset mid-frame
        do_reset();
        send(8'h1D); check_kbd("t6_pre", 8'h01);
        ps2_frame(8'h05, 1'b0, 5);
        reset = 1'b1;
        #1;
        check_kbd("t6_rst_kbd", 8'h00);
        check_eq("t6_rst_scan", 32'(bus.scan_code), 32'h0);
        check_eq("t6_rst_state", 32'(bus.rx_state), 32'(RX_IDLE));
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(3);
        send(8'h06); check_kbd("t6_kbd", 8'h40);

        // 7: random make/break traffic, checked by the model
        rnd_tbl = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h4B, 8'h05, 8'h06, 8'h04};
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) send(8'hF0);
            send(rnd_tbl[$urandom_range(0, 7)]);
        end
        send(8'h77);

        wait_cyc(10);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
